ppu_bg_line_fetcher: RTL and testbench
======================================

# ppu_bg_line_fetcher

Background scanline renderer for the PPU. It generalises the fixed 160-pixel, unscrolled background fetch into a parametrised engine with several additions:
- SCX/SCY scrolling, with tile-map wrap-around.
- Selectable tile-map base and selectable tile-data addressing mode.
- Configurable VRAM read latency.

It sits between the PPU mode sequencer, which pulses `line_start` at the start of mode 3, and the frame-buffer writer, which consumes `pixel_out`/`frame_wren`.

## Interface
Parameters:
- `SCREEN_W`, default 160: pixels emitted per line (multiple of 8, ≤ 256).
- `ADDR_W`, default 13: VRAM address width.
- `VRAM_LAT`, default 1: cycles from address valid to `vram_data` valid (≥ 1).

Ports (clock and reset first):
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `line_start`  in  1  one-cycle pulse that begins rendering line `line_y`.
- `line_y`  in  8  screen line number.
- `scx`, `scy`  in  8 each  scroll registers.
- `bg_map_sel`  in  1  0 → map at 0x1800, 1 → map at 0x1C00.
- `tile_data_sel`  in  1  1 → unsigned index from 0x0000; 0 → signed index around 0x1000.
- `bg_enable`  in  1  0 → emit colour 0 with no VRAM reads.
- `vram_data`  in  8  read data.
- `vram_addr`  out  `ADDR_W`  read address.
- `vram_rd`  out  1  read strobe.
- `pixel_out`  out  2  colour index.
- `X_out`, `Y_out`  out  8 each  screen coordinate of `pixel_out`.
- `frame_wren`  out  1  pixel valid.
- `busy`  out  1  high from the cycle after an accepted `line_start` through the `line_done` cycle.
- `line_done`  out  1  one-cycle pulse after the last pixel.

## Operation
Latching:
- `line_start` is accepted only in IDLE; while `busy`, it is ignored.
- On acceptance, the block latches `scx`, `scy`, `line_y`, `bg_map_sel`, `tile_data_sel` and `bg_enable`. Mid-line changes have no effect.

Coordinate arithmetic (all 8-bit, wrapping mod 256):
- `bg_y = line_y + scy`
- `bg_x = scx + px`, where `px` is the screen pixel counter, 0..`SCREEN_W`-1.

Address generation:
- Map address: `map_base + 32*bg_y[7:3] + bg_x[7:3]`.
- Tile row address, unsigned mode: `idx*16 + 2*bg_y[2:0]`.
- Tile row address, signed mode: `0x1000 + sext(idx)*16 + 2*bg_y[2:0]`.
- The high byte is at the row address + 1.

Pixel generation:
- Bit index `b = 7 - bg_x[2:0]`.
- `pixel_out = {hi[b], lo[b]}`.

FSM states: IDLE, MAP_FETCH, LO_FETCH, HI_FETCH, DRAW, DONE.
- Each FETCH state holds `vram_addr` with `vram_rd` high for `VRAM_LAT`+1 cycles and captures `vram_data` on the last of them. A wait counter, cleared on state entry, controls this.
- DRAW emits one pixel per cycle until either `bg_x[2:0]==7`, which goes to MAP_FETCH, or `px==SCREEN_W-1`, which goes to DONE.
- DONE lasts one cycle, pulses `line_done`, then returns to IDLE.

Edge cases:
- **Fine scroll:** the first tile emits `8 - scx[2:0]` pixels. The tile count is `SCREEN_W/8`, plus 1 if `scx[2:0]≠0`.
- **Horizontal wrap:** map column 31 wraps to column 0 within the same map row.
- **Background disabled:** with `bg_enable=0`, the block goes IDLE → DRAW directly and emits `SCREEN_W` zero pixels at one per cycle. `vram_rd` stays 0 throughout.

## Timing
Reset values:
- FSM in IDLE; `px` = 0.
- All outputs 0, including `vram_addr`, `X_out` and `pixel_out`.
- Asserting `reset` mid-line aborts immediately. No `line_done` is produced, and the block is in IDLE on the first edge after deassertion.

Latency:
- Let cycle 0 be the `line_start` edge; MAP_FETCH begins at cycle 1.
- With `VRAM_LAT=1`, each tile costs 6 fetch cycles plus its draw cycles.
- First pixel: cycle `1+3*(VRAM_LAT+1)` = 7.
- Line length, `scx[2:0]=0`, `SCREEN_W=160`: last pixel at cycle 280, `line_done` at cycle 281.
- Line length, `scx[2:0]=3`: 21 tiles, last pixel at cycle 286, `line_done` at cycle 287.
- With `bg_enable=0`: pixels on cycles 1..160, `line_done` at cycle 161.

Output alignment:
- `X_out`/`Y_out`/`pixel_out` are valid only while `frame_wren=1`.
- `X_out` = `px`; `Y_out` = latched `line_y`.

## Structure
- Package `ppu_pkg`: render-state enum, `MAP0_BASE=13'h1800`, `MAP1_BASE=13'h1C00`, `TILE_SIGNED_BASE=13'h1000`, and the PPU mode enum shared with the mode sequencer.
- Sub-module `ppu_tile_addr_gen`: purely combinational. It maps (state, latched selects, `bg_x`, `bg_y`, tile index) to `vram_addr`.
- Byte latches and the FSM stay in the top module.

## Test plan
- **Unscrolled line:** `scx=scy=0`, `line_y=0`, map[0]=1, tile 1 row 0 = lo 0xF0 / hi 0xCC. Required: `vram_addr` sequence 0x1800, 0x0010, 0x0011; first 8 pixels 3,3,1,1,2,2,0,0 at X=0..7; `line_done` at cycle 281.
- **Fine scroll:** `scx=3`. Required: first tile emits exactly 5 pixels (tile bits 4..0); 21 map fetches; `line_done` at cycle 287.
- **Wrap:** `scx=0xF8`, `scy=0xFF`, `line_y=1`. Required: first map address 0x181F; second 0x1800; row offset 2*0 for bg_y=0.
- **Signed mode:** `tile_data_sel=0`, index 0x80 → tile address 0x0800; index 0x7F → 0x17F0; `bg_map_sel=1` → map address 0x1C00.
- **Background disabled and ignored start:** `bg_enable=0` → 160 zero pixels on cycles 1..160, `vram_rd` never asserted. A second `line_start` at cycle 50 is ignored.
- **Latency and reset:** with `VRAM_LAT=3`, first pixel at cycle 13. `reset` asserted at cycle 100 → outputs 0 and IDLE, with no `line_done`.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: background render states, PPU modes and VRAM map/tile bases.
package ppu_pkg;

  typedef enum logic [2:0] {
    RS_IDLE      = 3'd0,
    RS_MAP_FETCH = 3'd1,
    RS_LO_FETCH  = 3'd2,
    RS_HI_FETCH  = 3'd3,
    RS_DRAW      = 3'd4,
    RS_DONE      = 3'd5
  } render_state_t;

  typedef enum logic [1:0] {
    MODE_HBLANK   = 2'd0,
    MODE_VBLANK   = 2'd1,
    MODE_OAM_SCAN = 2'd2,
    MODE_DRAW     = 2'd3
  } ppu_mode_t;

  localparam logic [12:0] MAP0_BASE        = 13'h1800;
  localparam logic [12:0] MAP1_BASE        = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;

endpackage

// File: rtl/ppu_tile_addr_gen.sv
// Combinational VRAM address for the current fetch: tile-map entry, then low/high byte
// of the selected tile row. Drives zero outside the fetch states.
module ppu_tile_addr_gen
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  render_state_t     i_state,
  input  logic              i_map_sel,
  input  logic              i_data_sel,
  input  logic [4:0]        i_bg_x_tile,
  input  logic [7:0]        i_bg_y,
  input  logic [7:0]        i_tile_idx,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_map_base;
  logic [ADDR_W-1:0] w_tile_base;
  logic [ADDR_W-1:0] w_row_base;

  always_comb begin
    w_map_base = i_map_sel ? ADDR_W'(MAP1_BASE) : ADDR_W'(MAP0_BASE);
    // signed mode: index is two's complement around the 0x1000 block
    if (i_data_sel) w_tile_base = ADDR_W'({i_tile_idx, 4'h0});
    else            w_tile_base = ADDR_W'(TILE_SIGNED_BASE) + ADDR_W'($signed({i_tile_idx, 4'h0}));
    w_row_base = w_tile_base + ADDR_W'({i_bg_y[2:0], 1'b0});

    o_addr = '0;
    case (i_state)
      RS_MAP_FETCH: o_addr = w_map_base + ADDR_W'({i_bg_y[7:3], i_bg_x_tile});
      RS_LO_FETCH:  o_addr = w_row_base;
      RS_HI_FETCH:  o_addr = w_row_base + ADDR_W'(1);
      default:      o_addr = '0;
    endcase
  end

endmodule

// File: rtl/ppu_bg_line_fetcher.sv
// Background scanline renderer: scrolled tile-map/tile-data fetch from VRAM and
// one-pixel-per-cycle output toward the frame-buffer writer.
module ppu_bg_line_fetcher
  import ppu_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned VRAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              line_start,
  input  logic [7:0]        line_y,
  input  logic [7:0]        scx,
  input  logic [7:0]        scy,
  input  logic              bg_map_sel,
  input  logic              tile_data_sel,
  input  logic              bg_enable,
  input  logic [7:0]        vram_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  output logic [1:0]        pixel_out,
  output logic [7:0]        X_out,
  output logic [7:0]        Y_out,
  output logic              frame_wren,
  output logic              busy,
  output logic              line_done
);

  localparam int unsigned WAIT_W = (VRAM_LAT > 1) ? $clog2(VRAM_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(VRAM_LAT);
  localparam logic [7:0] LAST_PX = 8'(SCREEN_W - 1);

  render_state_t     r_state;
  render_state_t     w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_px;
  logic [7:0]        r_scx;
  logic [7:0]        r_scy;
  logic [7:0]        r_line_y;
  logic              r_map_sel;
  logic              r_data_sel;
  logic              r_bg_en;
  logic [7:0]        r_tile_idx;
  logic [7:0]        r_lo;
  logic [7:0]        r_hi;

  logic [7:0]        w_bg_x;
  logic [7:0]        w_bg_y;
  logic [2:0]        w_bit;
  logic              w_fetch_last;
  logic [ADDR_W-1:0] w_addr;

  assign w_bg_x       = r_scx + r_px;
  assign w_bg_y       = r_line_y + r_scy;
  assign w_bit        = 3'd7 - w_bg_x[2:0];
  assign w_fetch_last = (r_wait == WAIT_LAST);

  ppu_tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_state     (r_state),
    .i_map_sel   (r_map_sel),
    .i_data_sel  (r_data_sel),
    .i_bg_x_tile (w_bg_x[7:3]),
    .i_bg_y      (w_bg_y),
    .i_tile_idx  (r_tile_idx),
    .o_addr      (w_addr)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RS_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      RS_IDLE:      if (line_start) w_next = bg_enable ? RS_MAP_FETCH : RS_DRAW;
      RS_MAP_FETCH: if (w_fetch_last) w_next = RS_LO_FETCH;
      RS_LO_FETCH:  if (w_fetch_last) w_next = RS_HI_FETCH;
      RS_HI_FETCH:  if (w_fetch_last) w_next = RS_DRAW;
      RS_DRAW: begin
        if (r_px == LAST_PX)                       w_next = RS_DONE;
        else if (r_bg_en && (w_bg_x[2:0] == 3'd7)) w_next = RS_MAP_FETCH;
      end
      RS_DONE:      w_next = RS_IDLE;
      default:      w_next = RS_IDLE;
    endcase
  end

  // Line parameters, pixel counter, fetch wait counter and fetched bytes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait     <= '0;
      r_px       <= '0;
      r_scx      <= '0;
      r_scy      <= '0;
      r_line_y   <= '0;
      r_map_sel  <= 1'b0;
      r_data_sel <= 1'b0;
      r_bg_en    <= 1'b0;
      r_tile_idx <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      r_wait <= (w_next != r_state) ? '0 : r_wait + WAIT_W'(1);
      if (r_state == RS_IDLE && line_start) begin
        r_px       <= '0;
        r_scx      <= scx;
        r_scy      <= scy;
        r_line_y   <= line_y;
        r_map_sel  <= bg_map_sel;
        r_data_sel <= tile_data_sel;
        r_bg_en    <= bg_enable;
      end
      if (r_state == RS_DRAW) r_px <= r_px + 8'd1;
      if (w_fetch_last) begin
        if (r_state == RS_MAP_FETCH) r_tile_idx <= vram_data;
        if (r_state == RS_LO_FETCH)  r_lo       <= vram_data;
        if (r_state == RS_HI_FETCH)  r_hi       <= vram_data;
      end
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    vram_rd    = 1'b0;
    vram_addr  = '0;
    pixel_out  = 2'b00;
    X_out      = '0;
    Y_out      = '0;
    frame_wren = 1'b0;
    busy       = (r_state != RS_IDLE);
    line_done  = 1'b0;
    case (r_state)
      RS_MAP_FETCH, RS_LO_FETCH, RS_HI_FETCH: begin
        vram_rd   = 1'b1;
        vram_addr = w_addr;
      end
      RS_DRAW: begin
        frame_wren = 1'b1;
        X_out      = r_px;
        Y_out      = r_line_y;
        if (r_bg_en) pixel_out = {r_hi[w_bit], r_lo[w_bit]};
      end
      RS_DONE:  line_done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_ppu_bg_line_fetcher.sv
// Self-checking bench for ppu_bg_line_fetcher: a VRAM model, a per-pixel scoreboard
// built from the address/pixel formulas, and a second instance with VRAM_LAT=3.
module tb_ppu_bg_line_fetcher;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] pix;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst, rst3;
  logic        line_start, ls3;
  logic [7:0]  line_y, scx, scy;
  logic        bg_map_sel, tile_data_sel, bg_enable;

  logic [7:0]  vram_data, vram_data3;
  logic [12:0] vram_addr, vram_addr3;
  logic        vram_rd, vram_rd3;
  logic [1:0]  pixel_out, pixel_out3;
  logic [7:0]  X_out, Y_out, X_out3, Y_out3;
  logic        frame_wren, frame_wren3, busy, busy3, line_done, line_done3;

  logic [7:0]  mem [0:8191];
  logic [7:0]  rd_p1;
  logic [7:0]  rd_p3 [3];

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [12:0] addr_log[$];
  logic [1:0]  pix_log[$];
  int          pcyc_log[$];
  int          rd_cnt;
  int          done_cyc;

  ppu_bg_line_fetcher #(.SCREEN_W(160), .ADDR_W(13), .VRAM_LAT(1)) dut (
    .clock(clk), .reset(rst), .line_start(line_start), .line_y(line_y), .scx(scx), .scy(scy),
    .bg_map_sel(bg_map_sel), .tile_data_sel(tile_data_sel), .bg_enable(bg_enable),
    .vram_data(vram_data), .vram_addr(vram_addr), .vram_rd(vram_rd), .pixel_out(pixel_out),
    .X_out(X_out), .Y_out(Y_out), .frame_wren(frame_wren), .busy(busy), .line_done(line_done)
  );

  ppu_bg_line_fetcher #(.SCREEN_W(160), .ADDR_W(13), .VRAM_LAT(3)) dut3 (
    .clock(clk), .reset(rst3), .line_start(ls3), .line_y(line_y), .scx(scx), .scy(scy),
    .bg_map_sel(bg_map_sel), .tile_data_sel(tile_data_sel), .bg_enable(bg_enable),
    .vram_data(vram_data3), .vram_addr(vram_addr3), .vram_rd(vram_rd3), .pixel_out(pixel_out3),
    .X_out(X_out3), .Y_out(Y_out3), .frame_wren(frame_wren3), .busy(busy3), .line_done(line_done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM: data valid VRAM_LAT cycles after the address
  always @(posedge clk) begin
    rd_p1    <= mem[vram_addr];
    rd_p3[0] <= mem[vram_addr3];
    rd_p3[1] <= rd_p3[0];
    rd_p3[2] <= rd_p3[1];
  end
  assign vram_data  = rd_p1;
  assign vram_data3 = rd_p3[2];

  function automatic logic [1:0] ref_pix(input int px, input logic [7:0] sx, input logic [7:0] sy,
                                         input logic [7:0] ly, input logic msel, input logic dsel);
    int bx, by, maddr, idx, taddr, b;
    logic [7:0] lo, hi;
    bx    = (int'(sx) + px) % 256;
    by    = (int'(ly) + int'(sy)) % 256;
    maddr = (msel ? 'h1C00 : 'h1800) + 32 * (by / 8) + (bx / 8);
    idx   = int'(mem[maddr]);
    if (dsel) taddr = idx * 16;
    else      taddr = 'h1000 + ((idx >= 128) ? idx - 256 : idx) * 16;
    taddr = taddr + 2 * (by % 8);
    lo = mem[taddr];
    hi = mem[taddr + 1];
    b  = 7 - (bx % 8);
    return {hi[b], lo[b]};
  endfunction

  // Runs one line on the VRAM_LAT=1 instance; restart_at>0 pulses line_start again mid-line
  // with altered inputs, which must not disturb the line.
  task automatic run_line(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] ly,
                          input logic msel, input logic dsel, input logic ben, input int restart_at);
    int ccount, exp_done;
    logic [7:0] bx;
    logic prev_rd;
    logic [12:0] prev_addr;
    exp_t e;
    bit fin;
    exp_q.delete(); addr_log.delete(); pix_log.delete(); pcyc_log.delete();
    rd_cnt = 0; done_cyc = -1;
    ccount = 1;
    for (int px = 0; px < 160; px++) begin
      bx = sx + 8'(px);
      if (ben && (px == 0 || bx[2:0] == 3'd0)) ccount += 6;
      e.x = 8'(px); e.y = ly; e.cyc = ccount;
      e.pix = ben ? ref_pix(px, sx, sy, ly, msel, dsel) : 2'd0;
      exp_q.push_back(e);
      ccount++;
    end
    exp_done = ccount;
    @(negedge clk);
    scx = sx; scy = sy; line_y = ly; bg_map_sel = msel; tile_data_sel = dsel; bg_enable = ben;
    line_start = 1'b1;
    fin = 0; prev_rd = 1'b0; prev_addr = '0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      line_start = (c == restart_at);
      if (c == restart_at) begin
        scx = ~sx; line_y = ly + 8'd7; bg_enable = ~ben; tile_data_sel = ~dsel;
      end
      if (vram_rd) begin
        rd_cnt++;
        if (!prev_rd || vram_addr !== prev_addr) addr_log.push_back(vram_addr);
      end
      prev_rd = vram_rd; prev_addr = vram_addr;
      if (frame_wren) begin
        pix_log.push_back(pixel_out);
        pcyc_log.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: got X=%0d at cycle %0d, required no more pixels", X_out, c);
        end else begin
          e = exp_q.pop_front();
          if ({pixel_out, X_out, Y_out} !== {e.pix, e.x, e.y} || c != e.cyc) begin
            errors++;
            $display("FAIL pixel: got pix=%0d X=%0d Y=%0d cycle=%0d, required pix=%0d X=%0d Y=%0d cycle=%0d",
                     pixel_out, X_out, Y_out, c, e.pix, e.x, e.y, e.cyc);
          end
        end
      end
      if (line_done) begin
        fin = 1;
        done_cyc = c;
      end
    end
    line_start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL line_done_timeout: got no line_done within 400 cycles, required one");
    end
    checks++;
    if (exp_q.size() != 0 || done_cyc != exp_done) begin
      errors++;
      $display("FAIL line_length: got %0d missing pixels, done at %0d, required 0 missing, done at %0d",
               exp_q.size(), done_cyc, exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vram_addr, vram_rd, pixel_out, X_out, Y_out, frame_wren, busy, line_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h rd=%b pix=%0d X=%0d Y=%0d wren=%b busy=%b done=%b, required all 0",
               vram_addr, vram_rd, pixel_out, X_out, Y_out, frame_wren, busy, line_done);
    end
    rst = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, frame_wren, vram_rd, line_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b wren=%b rd=%b done=%b, required 0", busy, frame_wren, vram_rd, line_done);
    end
  endtask

  task automatic test_unscrolled();
    int exp8[8] = '{3, 3, 1, 1, 2, 2, 0, 0};
    mem[13'h1800] = 8'h01; mem[13'h0010] = 8'hF0; mem[13'h0011] = 8'hCC;
    run_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 0);
    checks++;
    if (done_cyc != 281) begin
      errors++; $display("FAIL unscrolled_done: got cycle %0d, required 281", done_cyc);
    end
    checks++;
    if (addr_log.size() < 3 || addr_log[0] !== 13'h1800 || addr_log[1] !== 13'h0010 || addr_log[2] !== 13'h0011) begin
      errors++;
      $display("FAIL unscrolled_addr: got %0d addrs starting %h %h %h, required 1800 0010 0011",
               addr_log.size(), addr_log[0], addr_log[1], addr_log[2]);
    end
    checks++;
    if (pcyc_log.size() < 8 || pcyc_log[0] != 7) begin
      errors++; $display("FAIL first_pixel_cycle: got %0d, required 7", pcyc_log[0]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (int'(pix_log[i]) != exp8[i]) begin
          errors++; $display("FAIL unscrolled_pix%0d: got %0d, required %0d", i, pix_log[i], exp8[i]);
        end
      end
    end
  endtask

  task automatic test_fine_scroll();
    int exp5[5] = '{1, 2, 2, 0, 0};
    run_line(8'd3, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 0);
    checks++;
    if (done_cyc != 287 || addr_log.size() != 63) begin
      errors++;
      $display("FAIL fine_scroll_len: got done=%0d fetches=%0d, required done=287 fetches=63", done_cyc, addr_log.size());
    end
    checks++;
    if (pcyc_log.size() < 6 || pcyc_log[0] != 7 || pcyc_log[4] != 11 || pcyc_log[5] != 18) begin
      errors++;
      $display("FAIL fine_scroll_first_tile: got pixel cycles %0d/%0d/%0d, required 7/11/18",
               pcyc_log[0], pcyc_log[4], pcyc_log[5]);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (int'(pix_log[i]) != exp5[i]) begin
          errors++; $display("FAIL fine_scroll_pix%0d: got %0d, required %0d", i, pix_log[i], exp5[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    mem[13'h181F] = 8'h25;
    run_line(8'hF8, 8'hFF, 8'd1, 1'b0, 1'b1, 1'b1, 0);
    checks++;
    if (addr_log.size() < 4 || addr_log[0] !== 13'h181F || addr_log[1] !== 13'h0250 || addr_log[3] !== 13'h1800) begin
      errors++;
      $display("FAIL wrap_addr: got %h %h %h, required 181F 0250 1800", addr_log[0], addr_log[1], addr_log[3]);
    end
  endtask

  task automatic test_signed();
    mem[13'h1C00] = 8'h80; mem[13'h1C01] = 8'h7F;
    run_line(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 0);
    checks++;
    if (addr_log.size() < 5 || addr_log[0] !== 13'h1C00 || addr_log[1] !== 13'h0800 || addr_log[2] !== 13'h0801
        || addr_log[3] !== 13'h1C01 || addr_log[4] !== 13'h17F0) begin
      errors++;
      $display("FAIL signed_addr: got %h %h %h %h %h, required 1C00 0800 0801 1C01 17F0",
               addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[4]);
    end
  endtask

  task automatic test_bg_disabled();
    run_line(8'd5, 8'd9, 8'd42, 1'b0, 1'b1, 1'b0, 50);
    checks++;
    if (rd_cnt != 0 || done_cyc != 161 || pcyc_log.size() != 160 || pcyc_log[0] != 1) begin
      errors++;
      $display("FAIL bg_disabled: got rd=%0d done=%0d pixels=%0d first=%0d, required 0/161/160/1",
               rd_cnt, done_cyc, pcyc_log.size(), pcyc_log[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_wren !== 1'b0) begin
      errors++; $display("FAIL ignored_start: got busy=%b wren=%b after line, required 0", busy, frame_wren);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      run_line(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 143)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 0);
    end
  endtask

  task automatic test_latency_reset();
    int first;
    bit bad_after;
    logic busy_at_100;
    @(negedge clk);
    scx = 8'd0; scy = 8'd0; line_y = 8'd0; bg_map_sel = 1'b0; tile_data_sel = 1'b1; bg_enable = 1'b1;
    ls3 = 1'b1;
    first = -1; busy_at_100 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      ls3 = 1'b0;
      if (frame_wren3 && first < 0) first = c;
      if (c == 100) busy_at_100 = busy3;
    end
    checks++;
    if (first != 13 || busy_at_100 !== 1'b1) begin
      errors++; $display("FAIL lat3_first_pixel: got cycle %0d busy=%b, required 13 busy=1", first, busy_at_100);
    end
    rst3 = 1'b1;
    #1;
    checks++;
    if ({vram_addr3, vram_rd3, pixel_out3, X_out3, Y_out3, frame_wren3, busy3, line_done3} !== '0) begin
      errors++;
      $display("FAIL midline_reset: got addr=%h rd=%b X=%0d wren=%b busy=%b done=%b, required all 0",
               vram_addr3, vram_rd3, X_out3, frame_wren3, busy3, line_done3);
    end
    @(negedge clk);
    rst3 = 1'b0;
    bad_after = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (line_done3 || busy3 || frame_wren3 || vram_rd3) bad_after = 1;
    end
    checks++;
    if (bad_after) begin
      errors++; $display("FAIL after_reset_idle: got activity after reset, required idle with no line_done");
    end
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    line_start = 1'b0; ls3 = 1'b0;
    line_y = '0; scx = '0; scy = '0;
    bg_map_sel = 1'b0; tile_data_sel = 1'b1; bg_enable = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_unscrolled();
    test_fine_scroll();
    test_wrap();
    test_signed();
    test_bg_disabled();
    test_back_to_back();
    test_latency_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
